// File: rtl/mult_ctrl.sv
// mult_ctrl: sequential 32x32 multiplier that borrows the shared pipeline ALU.
// It runs one shift-add step per cycle (32 steps), fixes the sign, and then
// publishes a 64-bit product on hi/lo. It also raises stalls for the pipeline
// while a multiply is in flight or while a hi/lo read must wait.
module mult_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        MultStartE,
    input  logic        MultSgnE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        HiLoReadD,
    input  logic [31:0] ALUOut,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [2:0]  ALU_F,
    output logic        ALUGrant,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        MultDoneE,
    output logic        StallMult
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] ALU_ADD = 3'b010;

    logic [1:0]  state;
    logic [31:0] acc;
    logic [31:0] mplr;
    logic [31:0] mcand;
    logic [4:0]  count;
    logic        neg;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        carry;
    logic [63:0] product;
    logic [63:0] product_fixed;

    // Operand magnitudes are formed locally so capture never needs the ALU;
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        mag_a = (MultSgnE && SrcAE[31]) ? (~SrcAE + 32'd1) : SrcAE;
        mag_b = (MultSgnE && SrcBE[31]) ? (~SrcBE + 32'd1) : SrcBE;
    end

    // ALU operand mux: add the multiplicand (or zero) to the accumulator in ITER.
    always_comb begin
        ALU_A    = 32'd0;
        ALU_B    = 32'd0;
        ALU_F    = 3'b000;
        ALUGrant = 1'b0;
        if (state == ITER) begin
            ALU_A    = acc;
            ALU_B    = mplr[0] ? mcand : 32'd0;
            ALU_F    = ALU_ADD;
            ALUGrant = 1'b1;
        end
    end

    // Carry out of the 32-bit add is recovered from wrap-around of the sum.
    always_comb begin
        carry         = (ALUOut < ALU_A);
        product       = {acc, mplr};
        product_fixed = neg ? (~product + 64'd1) : product;
    end

    // Status outputs decoded from state; StallMult is combinational.
    always_comb begin
        busy      = (state == ITER) || (state == FIX);
        MultDoneE = (state == DONE);
        StallMult = busy || (HiLoReadD && (state != IDLE));
    end

    // Controller FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 32'd0;
            mplr  <= 32'd0;
            mcand <= 32'd0;
            count <= 5'd0;
            neg   <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (MultStartE) begin
                        mcand <= mag_a;
                        mplr  <= mag_b;
                        neg   <= MultSgnE & (SrcAE[31] ^ SrcBE[31]);
                        acc   <= 32'd0;
                        count <= 5'd0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    acc   <= {carry, ALUOut[31:1]};
                    mplr  <= {ALUOut[0], mplr[31:1]};
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= product_fixed[63:32];
                    lo    <= product_fixed[31:0];
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: scoreboard bench for mult_ctrl with a behavioural shared ALU.
module tb_mult_ctrl;

    logic        clk;
    logic        rst;
    logic        MultStartE;
    logic        MultSgnE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        HiLoReadD;
    logic [31:0] ALUOut;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [2:0]  ALU_F;
    logic        ALUGrant;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        MultDoneE;
    logic        StallMult;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    mult_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .MultStartE(MultStartE),
        .MultSgnE  (MultSgnE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .HiLoReadD (HiLoReadD),
        .ALUOut    (ALUOut),
        .ALU_A     (ALU_A),
        .ALU_B     (ALU_B),
        .ALU_F     (ALU_F),
        .ALUGrant  (ALUGrant),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .MultDoneE (MultDoneE),
        .StallMult (StallMult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared pipeline ALU: add when asked, zero otherwise.
    assign ALUOut = (ALU_F == 3'b010) ? (ALU_A + ALU_B) : 32'd0;

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // Issue one start edge and push the expected product; returns in cycle 1.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(negedge clk);
        SrcAE = a; SrcBE = b; MultSgnE = sgn; MultStartE = 1'b1;
        exp_q.push_back(ref_mult(a, b, sgn));
        @(posedge clk);
        @(negedge clk);
        MultStartE = 1'b0;
        SrcAE = $urandom; SrcBE = $urandom; MultSgnE = $urandom_range(0, 1);
    endtask

    // Advance (bounded) until MultDoneE, reporting the cycle index reached.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!MultDoneE && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; MultStartE = 1'b0; MultSgnE = 1'b0; SrcAE = 32'd0; SrcBE = 32'd0;
        HiLoReadD = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({hi, lo, busy, MultDoneE, StallMult, ALUGrant, ALU_A, ALU_B, ALU_F} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got hi=%h lo=%h busy=%b done=%b stall=%b grant=%b f=%b exp all zero",
                     hi, lo, busy, MultDoneE, StallMult, ALUGrant, ALU_F);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (StallMult !== 1'b0) begin
            failures++;
            $display("FAIL idle_hiloread_stall got %b exp 0", StallMult);
        end
        HiLoReadD = 1'b0;
        $display("txn reset: done");
    endtask

    task automatic test_unsigned_timing;
        logic [31:0] prev_hi, prev_lo;
        logic [63:0] exp;
        prev_hi = hi; prev_lo = lo;
        start_op(32'd3, 32'd5, 1'b0);
        for (int c = 1; c <= 35; c++) begin
            checks++;
            if (busy !== (c <= 33) || MultDoneE !== (c == 34) || ALUGrant !== (c <= 32) ||
                ALU_F !== ((c <= 32) ? 3'b010 : 3'b000)) begin
                failures++;
                $display("FAIL timing_c%0d got busy=%b done=%b grant=%b f=%b exp busy=%b done=%b grant=%b",
                         c, busy, MultDoneE, ALUGrant, ALU_F, c <= 33, c == 34, c <= 32);
            end
            if (c > 32) begin
                checks++;
                if (ALU_A !== 32'd0 || ALU_B !== 32'd0) begin
                    failures++;
                    $display("FAIL alu_idle_c%0d got a=%h b=%h exp 0", c, ALU_A, ALU_B);
                end
            end
            if (c <= 33) begin
                checks++;
                if (hi !== prev_hi || lo !== prev_lo) begin
                    failures++;
                    $display("FAIL hilo_hold_c%0d got %h_%h exp %h_%h", c, hi, lo, prev_hi, prev_lo);
                end
            end
            if (c == 34) begin
                exp = exp_q.pop_front();
                checks++;
                if ({hi, lo} !== exp || exp !== 64'h0000_0000_0000_000F) begin
                    failures++;
                    $display("FAIL mult_3x5 got %h_%h exp %h", hi, lo, exp);
                end
                $display("txn 3x5 unsigned: hi=%h lo=%h", hi, lo);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_products;
        logic [31:0] ta[6];
        logic [31:0] tb[6];
        logic        ts[6];
        logic [63:0] exp;
        int cyc;
        ta = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h1234_5678};
        tb = '{32'hFFFF_FFFF, 32'h0000_0003, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0007, 32'h8765_4321};
        ts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            start_op(ta[i], tb[i], ts[i]);
            wait_done(cyc);
            checks++;
            if (MultDoneE !== 1'b1 || cyc != 34) begin
                failures++;
                $display("FAIL latency_%0d got done=%b cycle=%0d exp done at 34", i, MultDoneE, cyc);
            end
            exp = exp_q.pop_front();
            checks++;
            if ({hi, lo} !== exp) begin
                failures++;
                $display("FAIL product_%0d got %h_%h exp %h", i, hi, lo, exp);
            end
            $display("txn %h x %h sgn=%b: hi=%h lo=%h", ta[i], tb[i], ts[i], hi, lo);
            @(negedge clk);
        end
    endtask

    task automatic test_restart_ignored;
        int dones;
        logic [63:0] exp;
        dones = 0;
        start_op(32'd7, 32'd9, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            if (MultDoneE) begin
                dones++;
                exp = exp_q.pop_front();
                checks++;
                if ({hi, lo} !== exp || c != 34) begin
                    failures++;
                    $display("FAIL restart_result got %h_%h at c%0d exp %h at c34", hi, lo, c, exp);
                end
            end
            MultStartE = (c == 10);
            if (c == 10) begin
                SrcAE = 32'hFFFF_FFF0; SrcBE = 32'h0000_1111; MultSgnE = 1'b1;
            end
            @(negedge clk);
        end
        MultStartE = 1'b0;
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL restart_pulses got %0d exp 1", dones);
        end
        $display("txn restart ignored: done pulses=%0d", dones);
    endtask

    task automatic test_hazard;
        int grants;
        logic [63:0] exp;
        grants = 0;
        @(negedge clk);
        SrcAE = 32'd11; SrcBE = 32'd13; MultSgnE = 1'b0; MultStartE = 1'b1; HiLoReadD = 1'b1;
        exp_q.push_back(ref_mult(32'd11, 32'd13, 1'b0));
        #1;
        checks++;
        if (StallMult !== 1'b0) begin
            failures++;
            $display("FAIL stall_at_start got %b exp 0", StallMult);
        end
        @(posedge clk);
        @(negedge clk);
        MultStartE = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            if (ALUGrant) grants++;
            checks++;
            if (StallMult !== (c <= 34)) begin
                failures++;
                $display("FAIL stall_c%0d got %b exp %b", c, StallMult, c <= 34);
            end
            if (c == 34) begin
                exp = exp_q.pop_front();
                checks++;
                if ({hi, lo} !== exp) begin
                    failures++;
                    $display("FAIL hazard_result got %h_%h exp %h", hi, lo, exp);
                end
            end
            @(negedge clk);
        end
        HiLoReadD = 1'b0;
        checks++;
        if (grants != 32) begin
            failures++;
            $display("FAIL grant_cycles got %0d exp 32", grants);
        end
        $display("txn hazard: grant cycles=%0d", grants);
    endtask

    task automatic test_reset_mid;
        int dones;
        int cyc;
        logic [63:0] exp;
        dones = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_op(32'h1234_5678, 32'h0000_5678, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        checks++;
        if (busy !== 1'b0 || StallMult !== 1'b0 || ALUGrant !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got busy=%b stall=%b grant=%b hi=%h lo=%h exp all zero",
                     busy, StallMult, ALUGrant, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (MultDoneE) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_abandon got dones=%0d hi=%h lo=%h exp 0 0 0", dones, hi, lo);
        end
        start_op(32'd3, 32'd5, 1'b0);
        wait_done(cyc);
        exp = exp_q.pop_front();
        checks++;
        if (MultDoneE !== 1'b1 || cyc != 34 || {hi, lo} !== exp) begin
            failures++;
            $display("FAIL after_reset got done=%b cyc=%0d %h_%h exp %h at 34", MultDoneE, cyc, hi, lo, exp);
        end
        $display("txn reset mid-op then 3x5: lo=%h", lo);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [31:0] a, b;
        logic s;
        logic [63:0] exp;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom; s = $urandom_range(0, 1);
            start_op(a, b, s);
            wait_done(cyc);
            exp = exp_q.pop_front();
            checks++;
            if (MultDoneE !== 1'b1 || {hi, lo} !== exp) begin
                failures++;
                $display("FAIL b2b_%0d got done=%b %h_%h exp %h", i, MultDoneE, hi, lo, exp);
            end
            $display("txn b2b %h x %h sgn=%b: hi=%h lo=%h", a, b, s, hi, lo);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_timing();
        test_products();
        test_restart_ignored();
        test_hazard();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
